// File: rtl/led_rate_sequencer_if.sv
// led_rate_sequencer_if: raw button input and rate/strobe outputs of the LED rate sequencer
interface led_rate_sequencer_if;
    logic       iBtn;
    logic       oTick;
    logic [1:0] oSpeedSel;
    logic       oRun;
    logic       oShortPress;
    logic       oLongPress;
    modport master (input iBtn, output oTick, oSpeedSel, oRun, oShortPress, oLongPress);
    modport slave  (output iBtn, input oTick, oSpeedSel, oRun, oShortPress, oLongPress);
endinterface

// File: rtl/led_rate_sequencer.sv
// led_rate_sequencer: debounces the button, classifies short/long presses and paces the LED step strobe
module led_rate_sequencer #(
    parameter int unsigned DEBOUNCE_CYC = 270000,
    parameter int unsigned LONG_CYC     = 27000000,
    parameter int unsigned PERIOD0      = 2700000,
    parameter int unsigned PERIOD1      = 13500000,
    parameter int unsigned PERIOD2      = 27000000,
    parameter int unsigned PERIOD3      = 54000000,
    parameter int unsigned CNT_W        = 26
) (
    input logic                  CLK,
    input logic                  RESETn,
    led_rate_sequencer_if.master ledIf
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] PER_LAST0 = CNT_W'(PERIOD0 - 1);
    localparam logic [CNT_W-1:0] PER_LAST1 = CNT_W'(PERIOD1 - 1);
    localparam logic [CNT_W-1:0] PER_LAST2 = CNT_W'(PERIOD2 - 1);
    localparam logic [CNT_W-1:0] PER_LAST3 = CNT_W'(PERIOD3 - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, TIMING, HELD} pressState_t;

    logic             btnMeta, btnSync, btnDeb, btnDebD;
    logic [CNT_W-1:0] debCnt, holdCnt, holdNext, periodCnt, periodLast;
    pressState_t      state, nextState;
    logic             press, release_, shortEv, longEv;
    logic             shortPulse, longPulse, run, clearPeriod, tick;
    logic [1:0]       speedSel;

    assign press       = btnDebD & ~btnDeb;
    assign release_    = ~btnDebD & btnDeb;
    assign clearPeriod = shortPulse | longPulse;
    assign tick        = run & ~clearPeriod & (periodCnt == periodLast);

    // two-flop synchroniser for the asynchronous button, idling at released
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            btnMeta <= 1'b1;
            btnSync <= 1'b1;
        end else begin
            btnMeta <= ledIf.iBtn;
            btnSync <= btnMeta;
        end
    end

    // debounced level follows the synchronised button after a full stable window
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            btnDeb  <= 1'b1;
            btnDebD <= 1'b1;
            debCnt  <= '0;
        end else begin
            btnDebD <= btnDeb;
            if (btnSync == btnDeb) begin
                debCnt <= '0;
            end else if (debCnt == DEB_LAST) begin
                btnDeb <= btnSync;
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + ONE;
            end
        end
    end

    // press classifier state and hold counter
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            holdCnt <= '0;
        end else begin
            state   <= nextState;
            holdCnt <= holdNext;
        end
    end

    // press classifier transitions; a release landing exactly on the long threshold counts as long
    always_comb begin
        nextState = state;
        holdNext  = holdCnt;
        shortEv   = 1'b0;
        longEv    = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    nextState = TIMING;
                    holdNext  = '0;
                end
            end
            TIMING: begin
                if (release_) begin
                    nextState = IDLE;
                    shortEv   = holdCnt < HOLD_LAST;
                    longEv    = holdCnt == HOLD_LAST;
                end else if (holdCnt == HOLD_LAST) begin
                    nextState = HELD;
                    longEv    = 1'b1;
                end else begin
                    holdNext = holdCnt + ONE;
                end
            end
            HELD: nextState = release_ ? IDLE : HELD;
            default: nextState = IDLE;
        endcase
    end

    // press pulses, speed index (wraps 3->0) and run flag act one cycle after classification
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            shortPulse <= 1'b0;
            longPulse  <= 1'b0;
            speedSel   <= 2'd0;
            run        <= 1'b1;
        end else begin
            shortPulse <= shortEv;
            longPulse  <= longEv;
            speedSel   <= speedSel + 2'(shortEv);
            run        <= run ^ longEv;
        end
    end

    // terminal count of the step period for the current speed
    always_comb begin
        periodLast = speedSel == 2'd0 ? PER_LAST0 :
                     speedSel == 2'd1 ? PER_LAST1 :
                     speedSel == 2'd2 ? PER_LAST2 : PER_LAST3;
    end

    // period counter; a press pulse restarts it so the next strobe is a full period away
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            periodCnt <= '0;
        end else begin
            periodCnt <= (clearPeriod || !run || periodCnt == periodLast) ? '0 : periodCnt + ONE;
        end
    end

    assign ledIf.oTick       = tick;
    assign ledIf.oSpeedSel   = speedSel;
    assign ledIf.oRun        = run;
    assign ledIf.oShortPress = shortPulse;
    assign ledIf.oLongPress  = longPulse;
endmodule

// File: tb/tb_led_rate_sequencer.sv
// tb_led_rate_sequencer: randomized and directed stimulus checked every cycle against a timestamp-based model
module tb_led_rate_sequencer;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int MAXC = 16384;
    localparam int PER [4] = '{3, 5, 8, 12};

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    led_rate_sequencer_if ledIf();

    led_rate_sequencer #(
        .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG),
        .PERIOD0(3), .PERIOD1(5), .PERIOD2(8), .PERIOD3(12), .CNT_W(26)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .ledIf(ledIf)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    bit bH [0:MAXC-1];
    bit dH [0:MAXC];
    int c = 0;
    int gCyc = 0;
    int mSpeed, mClear, mPressAt;
    bit mRun, mShortPend, mLongPend, mTiming, mHeld;
    int tickCount = 0, lastTickCyc = -1, prevTickCyc = -1;
    int shortCount = 0, lastShortCyc = -1, longCount = 0, lastLongCyc = -1;
    int pulseCyc = -1, gapAfterPulse = -1;
    bit waitFirst = 0;

    function automatic bit s2At(input int k);
        return (k < 2) ? 1'b1 : bH[k-2];
    endfunction

    // model and per-cycle comparison
    always @(negedge CLK) begin : cmp
        bit expTick, expShort, expLong, deb, debP, ok;
        if (!RESETn) begin
            chk("rst_tick", int'(ledIf.oTick), 0);
            chk("rst_speed", int'(ledIf.oSpeedSel), 0);
            chk("rst_run", int'(ledIf.oRun), 1);
            chk("rst_short", int'(ledIf.oShortPress), 0);
            chk("rst_long", int'(ledIf.oLongPress), 0);
            c = 0; mSpeed = 0; mRun = 1; mClear = -1; mShortPend = 0; mLongPend = 0;
            mTiming = 0; mHeld = 0; mPressAt = 0; dH[0] = 1; waitFirst = 0;
        end else begin
            if (c >= MAXC) $fatal(1, "FAIL model_capacity: got %0d cycles limit %0d", c, MAXC);
            bH[c] = ledIf.iBtn;
            expShort = mShortPend;
            expLong = mLongPend;
            if (mShortPend) begin mSpeed = (mSpeed + 1) % 4; mClear = c; end
            if (mLongPend) begin mRun = !mRun; mClear = c; end
            mShortPend = 0;
            mLongPend = 0;
            expTick = mRun && c > mClear && ((c - mClear) % PER[mSpeed]) == 0;
            chk("tick", int'(ledIf.oTick), int'(expTick));
            chk("speed", int'(ledIf.oSpeedSel), mSpeed);
            chk("run", int'(ledIf.oRun), int'(mRun));
            chk("short", int'(ledIf.oShortPress), int'(expShort));
            chk("long", int'(ledIf.oLongPress), int'(expLong));
            if (expShort || expLong) begin pulseCyc = gCyc; waitFirst = 1; gapAfterPulse = -1; end
            if (expShort) begin shortCount++; lastShortCyc = gCyc; end
            if (expLong) begin longCount++; lastLongCyc = gCyc; end
            if (expTick) begin
                tickCount++; prevTickCyc = lastTickCyc; lastTickCyc = gCyc;
                if (waitFirst) begin gapAfterPulse = gCyc - pulseCyc; waitFirst = 0; end
            end
            deb = dH[c];
            debP = (c > 0) ? dH[c-1] : 1'b1;
            if (!mTiming && !mHeld) begin
                if (debP && !deb) begin mTiming = 1; mPressAt = c; end
            end else if (mTiming) begin
                if (!debP && deb) begin
                    mTiming = 0;
                    if (c - mPressAt - 1 < LONG - 1) mShortPend = 1; else mLongPend = 1;
                end else if (c - mPressAt - 1 == LONG - 1) begin
                    mTiming = 0; mHeld = 1; mLongPend = 1;
                end
            end else if (!debP && deb) begin
                mHeld = 0;
            end
            ok = 1;
            for (int j = 0; j < DEB; j++) if (c - j < 0 || s2At(c - j) == deb) ok = 0;
            dH[c+1] = ok ? !deb : deb;
            c++;
            gCyc++;
        end
    end

    task automatic drive(input logic lvl, input int n);
        ledIf.iBtn = lvl;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic doReset(input logic lvl, input int n);
        RESETn = 1'b0;
        ledIf.iBtn = lvl;
        repeat (n) begin @(posedge CLK); #1; end
        RESETn = 1'b1;
    endtask

    // directed scenarios with hand-computed timing, then random presses
    initial begin : stim
        int up, down, sc, lc;
        int expSpd [3] = '{2, 3, 0};
        ledIf.iBtn = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESETn = 1'b1;
        drive(1, 12);
        chk("t1_tick_count", tickCount, 4);
        chk("t1_last_tick", lastTickCyc, 11);
        chk("t1_speed", int'(ledIf.oSpeedSel), 0);
        drive(0, 3);
        drive(1, 10);
        chk("t2_glitch_short", shortCount, 0);
        chk("t2_glitch_long", longCount, 0);
        drive(0, 8);
        up = gCyc;
        drive(1, 14);
        chk("t3_short_count", shortCount, 1);
        chk("t3_short_latency", lastShortCyc - up, 7);
        chk("t3_gap", gapAfterPulse, 5);
        chk("t3_speed", int'(ledIf.oSpeedSel), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 8);
            drive(1, 8 + 2 * PER[expSpd[i]]);
            chk("t4_speed", int'(ledIf.oSpeedSel), expSpd[i]);
            chk("t4_gap_first", gapAfterPulse, PER[expSpd[i]]);
            chk("t4_spacing", lastTickCyc - prevTickCyc, PER[expSpd[i]]);
        end
        chk("t4_short_count", shortCount, 4);
        down = gCyc;
        drive(0, 30);
        drive(1, 20);
        chk("t5_long_count", longCount, 1);
        chk("t5_long_latency", lastLongCyc - down, 27);
        chk("t5_run", int'(ledIf.oRun), 0);
        chk("t5_ticks_stop", int'(lastTickCyc < lastLongCyc), 1);
        chk("t5_no_short", shortCount, 4);
        drive(0, 30);
        drive(1, 20);
        chk("t5_long_count2", longCount, 2);
        chk("t5_run2", int'(ledIf.oRun), 1);
        chk("t5_resume_gap", gapAfterPulse, 3);
        drive(0, 8);
        drive(1, 12);
        chk("t6_speed_pre", int'(ledIf.oSpeedSel), 1);
        drive(0, 17);
        doReset(1, 3);
        chk("t6_speed_rst", int'(ledIf.oSpeedSel), 0);
        chk("t6_run_rst", int'(ledIf.oRun), 1);
        sc = shortCount;
        lc = longCount;
        drive(1, 20);
        chk("t6_no_short", shortCount, sc);
        chk("t6_no_long", longCount, lc);
        doReset(0, 2);
        up = gCyc;
        drive(0, 30);
        drive(1, 20);
        chk("t7_held_long", longCount, lc + 1);
        chk("t7_latency", lastLongCyc - up, 27);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) doReset(1'($urandom_range(0, 1)), 2);
            drive(0, $urandom_range(1, 30));
            drive(1, $urandom_range(1, 30));
        end
        drive(1, 40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
